// File: rtl/universal_shift_reg_n_pkg.sv
// -----------------------------------------------------------------------------
// universal_shift_reg_n_pkg
// Shared encodings for the universal shift register and its barrel network:
//   - MODO operating-mode encodings (SHIFT, ROTATE, PARA_LOAD, HOLD)
//   - DIR encodings (toward MSB / toward LSB)
//   - ENB active level
// -----------------------------------------------------------------------------
package universal_shift_reg_n_pkg;

  typedef enum logic [1:0] {
    SHIFT     = 2'b00,
    ROTATE    = 2'b01,
    PARA_LOAD = 2'b10,
    HOLD      = 2'b11
  } usr_mode_e;

  localparam logic DIR_LEFT   = 1'b0;  // toward MSB
  localparam logic DIR_RIGHT  = 1'b1;  // toward LSB

  localparam logic ENABLE_LVL = 1'b1;

endpackage

// File: rtl/universal_shift_reg_n_shift_net.sv
// -----------------------------------------------------------------------------
// usr_shift_net
// Combinational barrel network: computes the next register word and the last
// bit to leave it for a shift or rotate of distance i_k (1..WIDTH).
// Ports:
//   i_q     current register word
//   i_k     effective shift distance, 1..WIDTH
//   i_dir   DIR_LEFT (toward MSB) or DIR_RIGHT (toward LSB)
//   i_rot   1 = rotate (bits wrap), 0 = shift (vacated bits take i_fill)
//   i_fill  fill bit for shift mode
//   o_q     next register word
//   o_sout  last bit pushed out of the word
// -----------------------------------------------------------------------------
module usr_shift_net
  import universal_shift_reg_n_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int SW    = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] i_q,
  input  logic [SW:0]      i_k,
  input  logic             i_dir,
  input  logic             i_rot,
  input  logic             i_fill,
  output logic [WIDTH-1:0] o_q,
  output logic             o_sout
);

  localparam logic [SW:0] W_L = (SW+1)'(WIDTH);

  logic [WIDTH-1:0] w_src;
  logic [WIDTH-1:0] w_left;
  logic [WIDTH-1:0] w_right;
  logic [SW:0]      w_idx;

  // The bits entering the vacated end come from the word itself (rotate) or
  // from a word of fill bits (shift). Shifting a WIDTH-wide value by WIDTH
  // yields zero, so K = WIDTH falls out naturally: rotate returns i_q and
  // shift returns the all-fill word.
  assign w_src   = i_rot ? i_q : {WIDTH{i_fill}};
  assign w_left  = (i_q << i_k) | (w_src >> (W_L - i_k));
  assign w_right = (i_q >> i_k) | (w_src << (W_L - i_k));
  assign o_q     = (i_dir == DIR_RIGHT) ? w_right : w_left;

  // Last bit out: Q[K-1] going right, Q[WIDTH-K] going left.
  assign w_idx = (i_dir == DIR_RIGHT) ? (i_k - (SW+1)'(1)) : (W_L - i_k);

  always_comb begin
    o_sout = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      if (w_idx == (SW+1)'(i)) o_sout = i_q[i];
    end
  end

endmodule

// File: rtl/universal_shift_reg_n.sv
// -----------------------------------------------------------------------------
// universal_shift_reg_n
// Universal shift register: parallel load, shift or rotate by 1..WIDTH bits
// in either direction, with a saturating count of bits moved since the last
// load.
// Optional feature macro: USR_ARITH_SHIFT_EN -- when defined, a right shift
// with ARITH high refills vacated MSBs with the old MSB instead of S_IN.
// Ports:
//   CLK     clock, rising edge
//   RST_N   asynchronous active-low reset
//   ENB     enable; low holds all state
//   MODO    00 shift, 01 rotate, 10 parallel load, 11 hold
//   DIR     0 toward MSB, 1 toward LSB
//   SHAMT   shift distance minus one
//   S_IN    serial fill bit (shift mode)
//   ARITH   arithmetic right-shift request
//   D       parallel load data
//   Q       register contents
//   S_OUT   last bit to leave Q in the most recent shift/rotate
//   BITCNT  bits moved since last load, saturating at WIDTH
//   DONE    high while BITCNT == WIDTH
// -----------------------------------------------------------------------------
module universal_shift_reg_n
  import universal_shift_reg_n_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int SW    = $clog2(WIDTH)
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             ENB,
  input  logic [1:0]       MODO,
  input  logic             DIR,
  input  logic [SW-1:0]    SHAMT,
  input  logic             S_IN,
  input  logic             ARITH,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q,
  output logic             S_OUT,
  output logic [SW:0]      BITCNT,
  output logic             DONE
);

  localparam logic [SW:0] W_L = (SW+1)'(WIDTH);

  logic [WIDTH-1:0] r_q;
  logic             r_sout;
  logic [SW:0]      r_cnt;

  logic [SW:0]      w_k_raw;
  logic [SW:0]      w_k;
  logic             w_rot;
  logic             w_fill;
  logic [WIDTH-1:0] w_next_q;
  logic             w_next_sout;

  function automatic logic [SW:0] sat_add(input logic [SW:0] a,
                                          input logic [SW:0] b);
    logic [SW+1:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s > {1'b0, W_L}) return W_L;
    return s[SW:0];
  endfunction

  // When WIDTH is not a power of two SHAMT can encode distances beyond
  // WIDTH; those are treated as a full-width move.
  assign w_k_raw = {1'b0, SHAMT} + (SW+1)'(1);
  assign w_k     = (w_k_raw > W_L) ? W_L : w_k_raw;
  assign w_rot   = (MODO == ROTATE);

`ifdef USR_ARITH_SHIFT_EN
  // Sign extension only applies to right shifts; rotate ignores the fill bit.
  assign w_fill = ((DIR == DIR_RIGHT) && ARITH) ? r_q[WIDTH-1] : S_IN;
`else
  logic w_unused_arith;
  assign w_unused_arith = ARITH;
  assign w_fill         = S_IN;
`endif

  usr_shift_net #(
    .WIDTH (WIDTH),
    .SW    (SW)
  ) u_shift_net (
    .i_q    (r_q),
    .i_k    (w_k),
    .i_dir  (DIR),
    .i_rot  (w_rot),
    .i_fill (w_fill),
    .o_q    (w_next_q),
    .o_sout (w_next_sout)
  );

  // Register stage
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_q    <= '0;
      r_sout <= 1'b0;
      r_cnt  <= '0;
    end else if (ENB == ENABLE_LVL) begin
      case (usr_mode_e'(MODO))
        PARA_LOAD: begin
          r_q   <= D;
          r_cnt <= '0;
        end
        SHIFT, ROTATE: begin
          r_q    <= w_next_q;
          r_sout <= w_next_sout;
          r_cnt  <= sat_add(r_cnt, w_k);
        end
        default: ;
      endcase
    end
  end

  assign Q      = r_q;
  assign S_OUT  = r_sout;
  assign BITCNT = r_cnt;
  assign DONE   = (r_cnt == W_L);

endmodule

// File: tb/tb_universal_shift_reg_n.sv
module tb_universal_shift_reg_n;

  localparam int W  = 8;
  localparam int NV = 18;

`ifdef USR_ARITH_SHIFT_EN
  localparam bit         ARITH_EN  = 1'b1;
  localparam logic [7:0] ARITH_EXP = 8'hE4;
`else
  localparam bit         ARITH_EN  = 1'b0;
  localparam logic [7:0] ARITH_EXP = 8'h24;
`endif

  logic       CLK   = 1'b0;
  logic       RST_N = 1'b0;
  logic       ENB   = 1'b0;
  logic [1:0] MODO  = 2'b11;
  logic       DIR   = 1'b0;
  logic [2:0] SHAMT = 3'd0;
  logic       S_IN  = 1'b0;
  logic       ARITH = 1'b0;
  logic [7:0] D     = 8'h00;
  logic [7:0] Q;
  logic       S_OUT;
  logic [3:0] BITCNT;
  logic       DONE;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 CLK = ~CLK;

  universal_shift_reg_n #(.WIDTH(W)) dut (
    .CLK    (CLK),
    .RST_N  (RST_N),
    .ENB    (ENB),
    .MODO   (MODO),
    .DIR    (DIR),
    .SHAMT  (SHAMT),
    .S_IN   (S_IN),
    .ARITH  (ARITH),
    .D      (D),
    .Q      (Q),
    .S_OUT  (S_OUT),
    .BITCNT (BITCNT),
    .DONE   (DONE)
  );

  // Reference model: a K-bit move is K single-bit moves, one at a time.
  logic [7:0] m_q;
  logic       m_sout;
  int         m_cnt;

  task automatic model_step(input logic enb, input logic [1:0] modo,
                            input logic dir, input logic [2:0] shamt,
                            input logic sin, input logic arith,
                            input logic [7:0] d);
    int   k;
    logic msb;
    logic fill;
    if (!enb) return;
    if (modo == 2'b10) begin
      m_q   = d;
      m_cnt = 0;
    end else if (modo == 2'b00 || modo == 2'b01) begin
      k   = int'(shamt) + 1;
      msb = m_q[7];
      for (int s = 0; s < k; s++) begin
        if (dir == 1'b0) begin
          fill   = (modo == 2'b01) ? m_q[7] : sin;
          m_sout = m_q[7];
          m_q    = {m_q[6:0], fill};
        end else begin
          fill = (modo == 2'b01) ? m_q[0] : sin;
          if (modo == 2'b00 && arith && ARITH_EN) fill = msb;
          m_sout = m_q[0];
          m_q    = {fill, m_q[7:1]};
        end
      end
      m_cnt = (m_cnt + k > W) ? W : m_cnt + k;
    end
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic check_model(input string tag);
    check({tag, " Q"},      int'(Q),      int'(m_q));
    check({tag, " S_OUT"},  int'(S_OUT),  int'(m_sout));
    check({tag, " BITCNT"}, int'(BITCNT), m_cnt);
    check({tag, " DONE"},   int'(DONE),   (m_cnt == W) ? 1 : 0);
  endtask

  task automatic apply(input logic enb, input logic [1:0] modo,
                       input logic dir, input logic [2:0] shamt,
                       input logic sin, input logic arith,
                       input logic [7:0] d);
    @(negedge CLK);
    ENB = enb; MODO = modo; DIR = dir; SHAMT = shamt;
    S_IN = sin; ARITH = arith; D = d;
    @(posedge CLK);
    #1;
    model_step(enb, modo, dir, shamt, sin, arith, d);
  endtask

  typedef struct {
    logic       enb;
    logic [1:0] modo;
    logic       dir;
    logic [2:0] shamt;
    logic       sin;
    logic       arith;
    logic [7:0] d;
    logic [7:0] eq;
    logic       es;
    int         ec;
    logic       ed;
  } vec_t;

  vec_t tbl [NV];

  initial begin
    // enb  modo   dir   shamt sin   arith d      | Q     S_OUT BITCNT DONE
    tbl[0]  = '{1'b1, 2'b10, 1'b0, 3'd0, 1'b0, 1'b0, 8'h3C, 8'h3C, 1'b0, 0, 1'b0};
    tbl[1]  = '{1'b1, 2'b00, 1'b0, 3'd0, 1'b1, 1'b0, 8'h00, 8'h79, 1'b0, 1, 1'b0};
    tbl[2]  = '{1'b1, 2'b10, 1'b0, 3'd0, 1'b0, 1'b0, 8'h81, 8'h81, 1'b0, 0, 1'b0};
    tbl[3]  = '{1'b1, 2'b01, 1'b1, 3'd2, 1'b0, 1'b0, 8'h00, 8'h30, 1'b0, 3, 1'b0};
    tbl[4]  = '{1'b1, 2'b01, 1'b1, 3'd2, 1'b0, 1'b0, 8'h00, 8'h06, 1'b0, 6, 1'b0};
    tbl[5]  = '{1'b1, 2'b01, 1'b1, 3'd2, 1'b0, 1'b0, 8'h00, 8'hC0, 1'b1, 8, 1'b1};
    tbl[6]  = '{1'b1, 2'b10, 1'b0, 3'd0, 1'b0, 1'b0, 8'h90, 8'h90, 1'b1, 0, 1'b0};
    tbl[7]  = '{1'b1, 2'b00, 1'b1, 3'd1, 1'b0, 1'b1, 8'h00, ARITH_EXP, 1'b0, 2, 1'b0};
    tbl[8]  = '{1'b1, 2'b10, 1'b0, 3'd0, 1'b0, 1'b0, 8'h5A, 8'h5A, 1'b0, 0, 1'b0};
    tbl[9]  = '{1'b0, 2'b10, 1'b0, 3'd0, 1'b0, 1'b0, 8'hFF, 8'h5A, 1'b0, 0, 1'b0};
    tbl[10] = '{1'b0, 2'b10, 1'b0, 3'd0, 1'b0, 1'b0, 8'hFF, 8'h5A, 1'b0, 0, 1'b0};
    tbl[11] = '{1'b0, 2'b10, 1'b0, 3'd0, 1'b0, 1'b0, 8'hFF, 8'h5A, 1'b0, 0, 1'b0};
    tbl[12] = '{1'b1, 2'b11, 1'b0, 3'd0, 1'b0, 1'b0, 8'hFF, 8'h5A, 1'b0, 0, 1'b0};
    tbl[13] = '{1'b1, 2'b10, 1'b0, 3'd0, 1'b0, 1'b0, 8'h01, 8'h01, 1'b0, 0, 1'b0};
    tbl[14] = '{1'b1, 2'b00, 1'b0, 3'd7, 1'b1, 1'b0, 8'h00, 8'hFF, 1'b1, 8, 1'b1};
    tbl[15] = '{1'b1, 2'b00, 1'b0, 3'd0, 1'b0, 1'b0, 8'h00, 8'hFE, 1'b1, 8, 1'b1};
    tbl[16] = '{1'b1, 2'b01, 1'b0, 3'd7, 1'b0, 1'b0, 8'h00, 8'hFE, 1'b0, 8, 1'b1};
    tbl[17] = '{1'b1, 2'b00, 1'b1, 3'd7, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 8, 1'b1};

    m_q = 8'h00; m_sout = 1'b0; m_cnt = 0;

    // Power-on reset state
    repeat (2) @(posedge CLK);
    #1;
    check("reset Q",      int'(Q),      0);
    check("reset S_OUT",  int'(S_OUT),  0);
    check("reset BITCNT", int'(BITCNT), 0);
    check("reset DONE",   int'(DONE),   0);
    @(negedge CLK);
    RST_N = 1'b1;

    // Directed vector table
    for (int i = 0; i < NV; i++) begin
      apply(tbl[i].enb, tbl[i].modo, tbl[i].dir, tbl[i].shamt,
            tbl[i].sin, tbl[i].arith, tbl[i].d);
      check($sformatf("vec%0d Q", i),      int'(Q),      int'(tbl[i].eq));
      check($sformatf("vec%0d S_OUT", i),  int'(S_OUT),  int'(tbl[i].es));
      check($sformatf("vec%0d BITCNT", i), int'(BITCNT), tbl[i].ec);
      check($sformatf("vec%0d DONE", i),   int'(DONE),   int'(tbl[i].ed));
    end

    // Asynchronous reset mid-cycle with Q=A5, counter saturated
    apply(1'b1, 2'b10, 1'b0, 3'd0, 1'b0, 1'b0, 8'hA5);
    apply(1'b1, 2'b01, 1'b0, 3'd7, 1'b0, 1'b0, 8'h00);
    check("pre-reset Q",    int'(Q),    8'hA5);
    check("pre-reset DONE", int'(DONE), 1);
    #2;
    ENB   = 1'b0;
    RST_N = 1'b0;
    #1;
    check("async reset Q",      int'(Q),      0);
    check("async reset S_OUT",  int'(S_OUT),  0);
    check("async reset BITCNT", int'(BITCNT), 0);
    check("async reset DONE",   int'(DONE),   0);
    m_q = 8'h00; m_sout = 1'b0; m_cnt = 0;
    @(negedge CLK);
    RST_N = 1'b1;

    // First qualifying edge after reset release takes effect
    apply(1'b1, 2'b10, 1'b0, 3'd0, 1'b0, 1'b0, 8'h3C);
    check("post-reset load Q", int'(Q), 8'h3C);

    // Randomized traffic against the reference model
    for (int n = 0; n < 400; n++) begin
      apply(($urandom_range(0, 7) != 0), 2'($urandom_range(0, 3)),
            1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            8'($urandom_range(0, 255)));
      check_model($sformatf("rand%0d", n));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
